// File: rtl/buf_result_collector.sv
// Polls per-core result mailboxes round-robin, captures each posted (SAD, position)
// pair once per round and reports the minimum-SAD winner with a one-cycle done pulse.
module buf_result_collector #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDXW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [32*NUM_CORES-1:0] buf_val_1_bus,
    input  logic [32*NUM_CORES-1:0] buf_val_2_bus,
    input  logic [NUM_CORES-1:0]    buf_flag_bus,
    output logic [NUM_CORES-1:0]    ack,
    output logic                    busy,
    output logic                    done,
    output logic                    timed_out,
    output logic                    best_valid,
    output logic [31:0]             best_sad,
    output logic [31:0]             best_pos,
    output logic [IDXW-1:0]         best_core
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDXW-1:0] PTR_LAST = IDXW'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t              state;
    logic [IDXW-1:0]     ptr;
    logic [NUM_CORES-1:0] seen;
    logic [TW-1:0]       timer;

    logic                 capture;
    logic                 better;
    logic [31:0]          cur_sad;
    logic [31:0]          cur_pos;
    logic [NUM_CORES-1:0] ptr_onehot;
    logic [NUM_CORES-1:0] seen_next;
    logic [IDXW-1:0]      ptr_next;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == TIMER_LAST) ? t : t + TW'(1);
    endfunction

    // Candidate examined this cycle and whether it beats the current best
    always_comb begin
        ptr_onehot = NUM_CORES'(1) << ptr;
        cur_sad    = buf_val_1_bus[32*int'(ptr) +: 32];
        cur_pos    = buf_val_2_bus[32*int'(ptr) +: 32];
        capture    = buf_flag_bus[ptr] && !seen[ptr];
        better     = !best_valid || (cur_sad < best_sad) ||
                     ((cur_sad == best_sad) && (ptr < best_core));
        seen_next  = capture ? (seen | ptr_onehot) : seen;
        ptr_next   = (ptr == PTR_LAST) ? '0 : ptr + IDXW'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            seen       <= '0;
            timer      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            best_valid <= 1'b0;
            best_sad   <= 32'hFFFF_FFFF;
            best_pos   <= '0;
            best_core  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack  <= '0;
                    done <= 1'b0;
                    if (start) begin
                        state      <= COLLECT;
                        busy       <= 1'b1;
                        seen       <= '0;
                        ptr        <= '0;
                        timer      <= '0;
                        timed_out  <= 1'b0;
                        best_valid <= 1'b0;
                        best_sad   <= 32'hFFFF_FFFF;
                        best_pos   <= '0;
                        best_core  <= '0;
                    end
                end
                COLLECT: begin
                    ack   <= capture ? ptr_onehot : '0;
                    ptr   <= ptr_next;
                    timer <= sat_inc(timer);
                    seen  <= seen_next;
                    if (capture) begin
                        best_valid <= 1'b1;
                        if (better) begin
                            best_sad  <= cur_sad;
                            best_pos  <= cur_pos;
                            best_core <= ptr;
                        end
                    end
                    // Full coverage takes priority over a simultaneous timeout
                    if (&seen_next) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    ack   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_result_collector.sv
// Directed bench for buf_result_collector: one instance with the default timeout,
// one with a 16-cycle timeout for the timeout rounds.
module tb_buf_result_collector;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start;
    logic         start_b;
    logic [127:0] v1;
    logic [127:0] v2;
    logic [3:0]   flags;

    logic [3:0]   ack_a, ack_b;
    logic         busy_a, busy_b, done_a, done_b, to_a, to_b, bv_a, bv_b;
    logic [31:0]  sad_a, sad_b, pos_a, pos_b;
    logic [1:0]   core_a, core_b;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt_a = 0;

    buf_result_collector #(.NUM_CORES(4), .TIMEOUT_CYCLES(1024)) dut_a (
        .Clk(Clk), .Reset(Reset), .start(start),
        .buf_val_1_bus(v1), .buf_val_2_bus(v2), .buf_flag_bus(flags),
        .ack(ack_a), .busy(busy_a), .done(done_a), .timed_out(to_a),
        .best_valid(bv_a), .best_sad(sad_a), .best_pos(pos_a), .best_core(core_a)
    );

    buf_result_collector #(.NUM_CORES(4), .TIMEOUT_CYCLES(16)) dut_b (
        .Clk(Clk), .Reset(Reset), .start(start_b),
        .buf_val_1_bus(v1), .buf_val_2_bus(v2), .buf_flag_bus(flags),
        .ack(ack_b), .busy(busy_b), .done(done_b), .timed_out(to_b),
        .best_valid(bv_b), .best_sad(sad_b), .best_pos(pos_b), .best_core(core_b)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done_b(output int k);
        k = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_b === 1'b1) begin
                k = i;
                break;
            end
            @(negedge Clk);
        end
    endtask

    initial begin
        int k;
        int ack2;
        int cnt0;

        Reset = 1'b1; start = 1'b0; start_b = 1'b0; flags = '0; v1 = '0; v2 = '0;
        repeat (2) @(negedge Clk);
        check("rst_ack", 32'(ack_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_timed_out", 32'(to_a), 0);
        check("rst_valid", 32'(bv_a), 0);
        check("rst_sad", sad_a, 32'hFFFF_FFFF);
        check("rst_pos", pos_a, 0);
        check("rst_core", 32'(core_a), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Basic minimum search
        flags = 4'b1111;
        v1 = {32'd31, 32'd90, 32'd25, 32'd40};
        v2 = {32'h40, 32'h30, 32'h20, 32'h10};
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("basic_busy_n0", 32'(busy_a), 1);
        check("basic_ack_n0", 32'(ack_a), 0);
        @(negedge Clk);
        check("basic_ack_n1", 32'(ack_a), 4'b0001);
        check("basic_sad_n1", sad_a, 40);
        @(negedge Clk);
        check("basic_ack_n2", 32'(ack_a), 4'b0010);
        check("basic_sad_n2", sad_a, 25);
        @(negedge Clk);
        check("basic_ack_n3", 32'(ack_a), 4'b0100);
        @(negedge Clk);
        check("basic_ack_n4", 32'(ack_a), 4'b1000);
        check("basic_done", 32'(done_a), 1);
        check("basic_busy_n4", 32'(busy_a), 0);
        check("basic_sad", sad_a, 25);
        check("basic_pos", pos_a, 32'h20);
        check("basic_core", 32'(core_a), 1);
        check("basic_timed_out", 32'(to_a), 0);
        check("basic_valid", 32'(bv_a), 1);
        @(negedge Clk);
        check("basic_done_n5", 32'(done_a), 0);
        check("basic_ack_n5", 32'(ack_a), 0);

        // All SADs equal: lowest core index wins
        v1 = {32'd7, 32'd7, 32'd7, 32'd7};
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        check("tie_done", 32'(done_a), 1);
        check("tie_core", 32'(core_a), 0);
        check("tie_sad", sad_a, 7);
        check("tie_pos", pos_a, 32'h10);
        @(negedge Clk);

        // Core 2 posts late with the best value
        flags = 4'b1011;
        v1 = {32'd50, 32'd3, 32'd50, 32'd50};
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        k = -1; ack2 = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 20) flags[2] = 1'b1;
            if (ack_a[2] === 1'b1) ack2++;
            if (done_a === 1'b1) begin
                k = i;
                break;
            end
            @(negedge Clk);
        end
        check("late_done_cycle", 32'(k), 23);
        check("late_ack2_count", 32'(ack2), 1);
        check("late_core", 32'(core_a), 2);
        check("late_sad", sad_a, 3);
        check("late_pos", pos_a, 32'h30);
        check("late_timed_out", 32'(to_a), 0);
        @(negedge Clk);

        // start held high through DONE: next round accepted only from IDLE
        flags = 4'b1111;
        v1 = {32'd31, 32'd90, 32'd25, 32'd40};
        start = 1'b1;
        @(negedge Clk);
        repeat (4) @(negedge Clk);
        check("held_done", 32'(done_a), 1);
        check("held_sad_n4", sad_a, 25);
        @(negedge Clk);
        check("held_done_n5", 32'(done_a), 0);
        check("held_busy_n5", 32'(busy_a), 0);
        check("held_sad_n5", sad_a, 25);
        @(negedge Clk);
        check("held_busy_n6", 32'(busy_a), 1);
        check("held_sad_n6", sad_a, 32'hFFFF_FFFF);
        check("held_valid_n6", 32'(bv_a), 0);
        check("held_core_n6", 32'(core_a), 0);
        start = 1'b0;
        repeat (6) @(negedge Clk);

        // Timeout with only core 3 posting
        flags = 4'b1000;
        v1 = {32'd9, 32'd60, 32'd60, 32'd60};
        start_b = 1'b1;
        @(negedge Clk);
        start_b = 1'b0;
        wait_done_b(k);
        check("to_done_cycle", 32'(k), 16);
        check("to_timed_out", 32'(to_b), 1);
        check("to_valid", 32'(bv_b), 1);
        check("to_core", 32'(core_b), 3);
        check("to_sad", sad_b, 9);
        repeat (3) @(negedge Clk);
        check("to_held", 32'(to_b), 1);
        check("to_done_after", 32'(done_b), 0);

        // Timeout with no flags at all
        flags = 4'b0000;
        start_b = 1'b1;
        @(negedge Clk);
        start_b = 1'b0;
        check("noflag_timed_out_cleared", 32'(to_b), 0);
        wait_done_b(k);
        check("noflag_done_cycle", 32'(k), 16);
        check("noflag_timed_out", 32'(to_b), 1);
        check("noflag_valid", 32'(bv_b), 0);
        check("noflag_sad", sad_b, 32'hFFFF_FFFF);
        @(negedge Clk);

        // Asynchronous reset in the middle of a round
        flags = 4'b1111;
        cnt0 = done_cnt_a;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        check("mid_ack_before", 32'(ack_a), 4'b0001);
        #2 Reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy_a), 0);
        check("mid_ack", 32'(ack_a), 0);
        check("mid_sad", sad_a, 32'hFFFF_FFFF);
        check("mid_valid", 32'(bv_a), 0);
        check("mid_pos", pos_a, 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        check("mid_no_done", 32'(done_cnt_a - cnt0), 0);
        check("mid_ack_after", 32'(ack_a), 0);
        check("mid_busy_after", 32'(busy_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
